// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: default widths, default address,
// FSM state encoding and the saturating bit-counter helper.
package i2c_pkg;

  localparam int         I2C_ADDR_WIDTH_DEF = 7;
  localparam int         I2C_DATA_WIDTH_DEF = 8;
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h22;
  localparam logic [3:0] BIT_CNT_MAX        = 4'd9;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    WR_DATA  = 4'd3,
    WR_ACK   = 4'd4,
    RD_WAIT  = 4'd5,
    RD_DATA  = 4'd6,
    RD_ACK   = 4'd7,
    IGNORE   = 4'd8
  } i2c_state_t;

  // Bit counter saturates so a runaway clock can never wrap it back to a match.
  function automatic logic [3:0] bit_cnt_inc(input logic [3:0] cnt);
    return (cnt >= BIT_CNT_MAX) ? BIT_CNT_MAX : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings the raw SCL/SDA levels into clk_i, then derives SCL edges and
// START/STOP conditions from the synchronized values only.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise_s,
  output logic scl_fall_s,
  output logic start_s,
  output logic stop_s
);

  logic [1:0] scl_sync_r;
  logic [1:0] sda_sync_r;
  logic       scl_prev_r;
  logic       sda_prev_r;
  logic       scl_now_s;

  // Two-flop synchronizers followed by a one-cycle history for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_i};
      sda_sync_r <= {sda_sync_r[0], sda_i};
      scl_prev_r <= scl_sync_r[1];
      sda_prev_r <= sda_sync_r[1];
    end
  end

  assign scl_now_s  = scl_sync_r[1];
  assign sda_s      = sda_sync_r[1];
  assign scl_rise_s = scl_now_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_now_s & scl_prev_r;
  // SCL must be stable high across both samples so a clock edge is never read as START/STOP.
  assign start_s    = scl_now_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s     = scl_now_s & scl_prev_r & ~sda_prev_r & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, byte write to host, clock-stretched byte read
// from host. SCL/SDA outputs are open-drain enables (0 = pull low).
module i2c_target
  import i2c_pkg::*;
#(
  parameter int                        I2C_ADDR_WIDTH = I2C_ADDR_WIDTH_DEF,
  parameter int                        I2C_DATA_WIDTH = I2C_DATA_WIDTH_DEF,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDRESS  = DEFAULT_SLAVE_ADDR
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_o,
  output logic                      sda_o,
  output logic                      wr_valid,
  output logic [I2C_DATA_WIDTH-1:0] wr_data,
  output logic                      rd_req,
  input  logic                      rd_valid,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data,
  output logic                      busy,
  output logic                      xfer_start,
  output logic                      xfer_rw
);

  localparam int         SH_W      = (I2C_ADDR_WIDTH + 1 > I2C_DATA_WIDTH) ?
                                     I2C_ADDR_WIDTH + 1 : I2C_DATA_WIDTH;
  localparam logic [3:0] ADDR_LAST = 4'(I2C_ADDR_WIDTH);
  localparam logic [3:0] DATA_LAST = 4'(I2C_DATA_WIDTH - 1);
  localparam logic [3:0] DATA_DONE = 4'(I2C_DATA_WIDTH);

  logic sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  i2c_bus_sync u_bus_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_s      (sda_s),
    .scl_rise_s (scl_rise_s),
    .scl_fall_s (scl_fall_s),
    .start_s    (start_s),
    .stop_s     (stop_s)
  );

  i2c_state_t                state_r;
  logic [3:0]                bit_cnt_r;
  logic [SH_W-2:0]           rx_r;
  logic [SH_W-1:0]           rx_next_s;
  logic [I2C_DATA_WIDTH-1:0] tx_r;
  logic                      ack_phase_r;
  logic                      scl_r, sda_r, wr_valid_r, rd_req_r, busy_r, xfer_start_r, xfer_rw_r;
  logic [I2C_DATA_WIDTH-1:0] wr_data_r;

  assign rx_next_s = {rx_r, sda_s};

  // Protocol FSM; START/STOP override whatever else happens in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 4'd0;
      rx_r         <= '0;
      tx_r         <= '0;
      ack_phase_r  <= 1'b0;
      scl_r        <= 1'b1;
      sda_r        <= 1'b1;
      wr_valid_r   <= 1'b0;
      wr_data_r    <= '0;
      rd_req_r     <= 1'b0;
      busy_r       <= 1'b0;
      xfer_start_r <= 1'b0;
      xfer_rw_r    <= 1'b0;
    end else begin
      wr_valid_r   <= 1'b0;
      rd_req_r     <= 1'b0;
      xfer_start_r <= 1'b0;
      if (stop_s) begin
        state_r     <= IDLE;
        bit_cnt_r   <= 4'd0;
        ack_phase_r <= 1'b0;
        scl_r       <= 1'b1;
        sda_r       <= 1'b1;
        busy_r      <= 1'b0;
      end else if (start_s) begin
        state_r     <= ADDR;
        bit_cnt_r   <= 4'd0;
        ack_phase_r <= 1'b0;
        scl_r       <= 1'b1;
        sda_r       <= 1'b1;
        busy_r      <= 1'b0;
      end else begin
        case (state_r)
          IDLE, IGNORE: begin
            scl_r <= 1'b1;
            sda_r <= 1'b1;
          end
          ADDR: begin
            if (scl_rise_s) begin
              rx_r      <= rx_next_s[SH_W-2:0];
              bit_cnt_r <= bit_cnt_inc(bit_cnt_r);
              if (bit_cnt_r == ADDR_LAST) begin
                if (rx_next_s[I2C_ADDR_WIDTH:1] == SLAVE_ADDRESS) begin
                  state_r      <= ADDR_ACK;
                  ack_phase_r  <= 1'b0;
                  xfer_start_r <= 1'b1;
                  xfer_rw_r    <= rx_next_s[0];
                  busy_r       <= 1'b1;
                end else begin
                  state_r <= IGNORE;
                end
              end
            end
          end
          ADDR_ACK, WR_ACK: begin
            // First SCL fall starts the ACK low, the second one ends it.
            if (scl_fall_s) begin
              if (!ack_phase_r) begin
                sda_r       <= 1'b0;
                ack_phase_r <= 1'b1;
              end else begin
                sda_r       <= 1'b1;
                ack_phase_r <= 1'b0;
                bit_cnt_r   <= 4'd0;
                if (state_r == ADDR_ACK && xfer_rw_r) begin
                  state_r  <= RD_WAIT;
                  scl_r    <= 1'b0;
                  rd_req_r <= 1'b1;
                end else begin
                  state_r <= WR_DATA;
                end
              end
            end
          end
          WR_DATA: begin
            if (scl_rise_s) begin
              rx_r      <= rx_next_s[SH_W-2:0];
              bit_cnt_r <= bit_cnt_inc(bit_cnt_r);
              if (bit_cnt_r == DATA_LAST) begin
                wr_valid_r  <= 1'b1;
                wr_data_r   <= rx_next_s[I2C_DATA_WIDTH-1:0];
                state_r     <= WR_ACK;
                ack_phase_r <= 1'b0;
              end
            end
          end
          RD_WAIT: begin
            if (rd_valid) begin
              sda_r     <= rd_data[I2C_DATA_WIDTH-1];
              tx_r      <= {rd_data[I2C_DATA_WIDTH-2:0], 1'b0};
              scl_r     <= 1'b1;
              bit_cnt_r <= 4'd0;
              state_r   <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (scl_rise_s) begin
              bit_cnt_r <= bit_cnt_inc(bit_cnt_r);
            end else if (scl_fall_s) begin
              if (bit_cnt_r == DATA_DONE) begin
                sda_r   <= 1'b1;
                state_r <= RD_ACK;
              end else begin
                sda_r <= tx_r[I2C_DATA_WIDTH-1];
                tx_r  <= {tx_r[I2C_DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            // The counter reaches its saturation value on the ACK clock rise.
            if (scl_rise_s) begin
              bit_cnt_r <= bit_cnt_inc(bit_cnt_r);
              if (sda_s) begin
                state_r <= IGNORE;
                busy_r  <= 1'b0;
              end
            end else if (scl_fall_s && bit_cnt_r == BIT_CNT_MAX) begin
              state_r   <= RD_WAIT;
              scl_r     <= 1'b0;
              rd_req_r  <= 1'b1;
              bit_cnt_r <= 4'd0;
            end
          end
          default: begin
            state_r <= IDLE;
            scl_r   <= 1'b1;
            sda_r   <= 1'b1;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign scl_o      = scl_r;
  assign sda_o      = sda_r;
  assign wr_valid   = wr_valid_r;
  assign wr_data    = wr_data_r;
  assign rd_req     = rd_req_r;
  assign busy       = busy_r;
  assign xfer_start = xfer_start_r;
  assign xfer_rw    = xfer_rw_r;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: an open-drain bus model, a bit-level master,
// a delayed host read responder and a table of write/mismatch transfers.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_i, scl_m, sda_m, rd_valid;
  logic [7:0] rd_data;
  logic       scl_o, sda_o, wr_valid, rd_req, busy, xfer_start, xfer_rw;
  logic [7:0] wr_data;
  logic       scl_bus, sda_bus;

  assign scl_bus = scl_m & scl_o;
  assign sda_bus = sda_m & sda_o;

  i2c_target #(.I2C_ADDR_WIDTH(7), .I2C_DATA_WIDTH(8), .SLAVE_ADDRESS(7'h22)) dut (
    .clk_i(clk), .rst_i(rst_i), .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_o(scl_o), .sda_o(sda_o), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .xfer_start(xfer_start), .xfer_rw(xfer_rw)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_bad = 0;
  int         wr_cnt = 0, rd_req_cnt = 0, xs_cnt = 0, cur_low = 0, max_low = 0;
  logic [7:0] last_wr = 8'h00;
  logic       last_rw = 1'b0;
  logic       host_en;
  logic [7:0] rd_bytes [4];

  // Event monitor: pulse counters, last captured values, longest SCL stretch.
  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cnt  <= wr_cnt + 1;
      last_wr <= wr_data;
    end
    if (rd_req) rd_req_cnt <= rd_req_cnt + 1;
    if (xfer_start) begin
      xs_cnt  <= xs_cnt + 1;
      last_rw <= xfer_rw;
      max_low <= 0;
    end else if (!scl_o && cur_low + 1 > max_low) begin
      max_low <= cur_low + 1;
    end
    cur_low <= scl_o ? 0 : cur_low + 1;
  end

  // Host side: answers each rd_req 20 clocks later with the next table byte.
  initial begin
    int idx;
    idx = 0;
    rd_valid = 1'b0;
    rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_req && host_en) begin
        repeat (20) @(negedge clk);
        rd_data  = rd_bytes[idx];
        idx      = idx + 1;
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int n;
    n = 0;
    while (scl_bus !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (scl_bus !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scl_release: actual=%b required=1", scl_bus);
    end
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    sda_m = b;
    wait_q();
    scl_m = 1'b1;
    wait_scl_high();
    wait_q();
    r = sda_bus;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_scl_high();
    wait_q();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b1;
    wait_scl_high();
    wait_q();
    sda_m = 1'b1;
    wait_q();
    wait_q();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack_bit);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
    xfer_bit(1'b1, ack_bit);
  endtask

  task automatic rbyte(input logic ack_bit, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      d[i] = r;
    end
    xfer_bit(ack_bit, r);
  endtask

  typedef struct {
    logic [7:0] addr;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       match;
  } wvec_t;

  wvec_t tbl [5];

  initial begin
    logic       r, exp_ack;
    logic [7:0] d, dv;
    int         wr0, xs0, rq0;

    tbl[0] = '{8'h44, 2, 8'hA5, 8'h3C, 1'b1};
    tbl[1] = '{8'h50, 1, 8'h12, 8'h00, 1'b0};
    tbl[2] = '{8'h44, 2, 8'h00, 8'hFF, 1'b1};
    tbl[3] = '{8'h43, 1, 8'h5A, 8'h00, 1'b0};
    tbl[4] = '{8'hC4, 1, 8'h81, 8'h00, 1'b0};
    rd_bytes[0] = 8'h96;
    rd_bytes[1] = 8'h5A;
    rd_bytes[2] = 8'h77;
    rd_bytes[3] = 8'h00;
    host_en = 1'b1;
    rst_i = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_outputs", 32'({scl_o, sda_o, wr_valid, rd_req, busy, xfer_start, xfer_rw}), 32'h60);
    chk("reset_wr_data", 32'(wr_data), 32'h0);
    rst_i = 1'b0;
    repeat (10) @(negedge clk);

    // Write and address-mismatch transfers.
    for (int t = 0; t < 5; t++) begin
      wr0 = wr_cnt; xs0 = xs_cnt; rq0 = rd_req_cnt;
      exp_ack = !tbl[t].match;
      i2c_start();
      wbyte(tbl[t].addr, r);
      chk("addr_ack", 32'(r), 32'(exp_ack));
      chk("busy_addressed", 32'(busy), 32'(tbl[t].match));
      for (int j = 0; j < tbl[t].n; j++) begin
        dv = (j == 0) ? tbl[t].d0 : tbl[t].d1;
        wbyte(dv, r);
        chk("data_ack", 32'(r), 32'(exp_ack));
        if (tbl[t].match) chk("wr_data", 32'(last_wr), 32'(dv));
      end
      i2c_stop();
      chk("wr_count", 32'(wr_cnt - wr0), tbl[t].match ? 32'(tbl[t].n) : 32'd0);
      chk("xfer_start_count", 32'(xs_cnt - xs0), 32'(tbl[t].match));
      if (tbl[t].match) chk("xfer_rw_write", 32'(last_rw), 32'd0);
      chk("busy_after_stop", 32'(busy), 32'd0);
      chk("no_rd_req", 32'(rd_req_cnt - rq0), 32'd0);
    end

    // Read: two bytes, master ACKs then NACKs, host answers after 20 clocks.
    wr0 = wr_cnt; rq0 = rd_req_cnt;
    i2c_start();
    wbyte(8'h45, r);
    chk("rd_addr_ack", 32'(r), 32'd0);
    chk("rd_xfer_rw", 32'(last_rw), 32'd1);
    rbyte(1'b0, d);
    chk("rd_byte0", 32'(d), 32'h96);
    rbyte(1'b1, d);
    chk("rd_byte1", 32'(d), 32'h5A);
    chk("rd_busy_after_nack", 32'(busy), 32'd0);
    i2c_stop();
    chk("rd_req_count", 32'(rd_req_cnt - rq0), 32'd2);
    chk("rd_stretch_ge20", 32'(max_low >= 20), 32'd1);
    chk("rd_no_wr", 32'(wr_cnt - wr0), 32'd0);

    // Repeated START: write one byte, then re-address for a read.
    wr0 = wr_cnt; xs0 = xs_cnt;
    i2c_start();
    wbyte(8'h44, r);
    chk("rs_waddr_ack", 32'(r), 32'd0);
    wbyte(8'h01, r);
    chk("rs_data_ack", 32'(r), 32'd0);
    chk("rs_wr_data", 32'(last_wr), 32'h01);
    i2c_start();
    wbyte(8'h45, r);
    chk("rs_raddr_ack", 32'(r), 32'd0);
    chk("rs_xfer_rw", 32'(last_rw), 32'd1);
    chk("rs_xfer_start_count", 32'(xs_cnt - xs0), 32'd2);
    rbyte(1'b1, d);
    chk("rs_rd_byte", 32'(d), 32'h77);
    i2c_stop();
    chk("rs_wr_count", 32'(wr_cnt - wr0), 32'd1);

    // STOP after four data bits must not produce a byte.
    wr0 = wr_cnt;
    i2c_start();
    wbyte(8'h44, r);
    chk("mid_addr_ack", 32'(r), 32'd0);
    xfer_bit(1'b1, r);
    xfer_bit(1'b0, r);
    xfer_bit(1'b1, r);
    xfer_bit(1'b0, r);
    chk("mid_busy_before_stop", 32'(busy), 32'd1);
    i2c_stop();
    chk("mid_no_wr_valid", 32'(wr_cnt - wr0), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_state_idle", 32'(dut.state_r), 32'(IDLE));

    // Reset while the target stretches SCL waiting for read data.
    host_en = 1'b0;
    i2c_start();
    wbyte(8'h45, r);
    chk("rst_addr_ack", 32'(r), 32'd0);
    repeat (10) @(negedge clk);
    chk("rst_stretching", 32'(scl_o), 32'd0);
    rst_i = 1'b1;
    #1;
    chk("rst_scl_released", 32'(scl_o), 32'd1);
    chk("rst_sda_released", 32'(sda_o), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    rst_i = 1'b0;
    repeat (10) @(negedge clk);
    i2c_start();
    wbyte(8'h44, r);
    chk("post_rst_ack", 32'(r), 32'd0);
    i2c_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
